// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Optional checksum support is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned LEN_W  = 2 * BYTE_W;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  // States in which the loader consumes a byte from the stream
  function automatic logic is_rx_state(input state_e s);
    return (s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM});
  endfunction

  function automatic logic is_busy_state(input state_e s);
    return !(s inside {S_IDLE, S_DONE, S_ERR});
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic                load_req;
  logic [BYTE_W-1:0]   rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                busy;
  logic                done;
  logic                error;
  logic                cpu_start;

  modport slave (
    input  load_req, rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_start
  );

  modport master (
    output load_req, rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_start
  );

endinterface

// File: rtl/imem_loader_csum.sv
// XOR checksum accumulator over the loaded byte stream; only instantiated
// when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader_csum
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_match_c
);

  logic [BYTE_W-1:0] r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_byte;
    end
  end

  // Trailing byte is compared against the sum of everything before it
  assign o_match_c = (r_acc == i_byte);

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader writing big-endian 16-bit words to
// instruction memory. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  imem_loader_if.slave bus
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_start;
  logic               w_accept;
  logic [LEN_W-1:0]   w_len_full;
  logic               w_len_bad;
  logic               w_last;

  logic               r_rx_ready;
  logic               r_wr_en;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic               r_cpu_start;

  logic [LEN_W-1:0]   r_len;
  logic [BYTE_W-1:0]  r_hi;
  logic [ADDR_W-1:0]  r_addr;
  logic [CNT_W-1:0]   r_count;

  assign w_accept   = bus.rx_valid & r_rx_ready;
  assign w_len_full = {r_len[LEN_W-1 -: BYTE_W], bus.rx_data};
  assign w_len_bad  = (w_len_full == '0) || (w_len_full > LEN_W'(DEPTH));
  assign w_last     = ((LEN_W'(r_count) + LEN_W'(1)) == r_len);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic w_csum_match;

  imem_loader_csum u_csum (
    .clk       (clock),
    .rst_n     (reset),
    .i_clr     (w_start),
    .i_en      (w_accept && (r_state != S_CSUM)),
    .i_byte    (bus.rx_data),
    .o_match_c (w_csum_match)
  );

  localparam state_e S_AFTER_LAST = S_CSUM;
`else
  localparam state_e S_AFTER_LAST = S_DONE;
`endif

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.load_req) begin
          w_state_nxt = S_LEN_HI;
          w_start     = 1'b1;
        end
      end
      S_LEN_HI:  if (w_accept) w_state_nxt = S_LEN_LO;
      S_LEN_LO:  if (w_accept) w_state_nxt = w_len_bad ? S_ERR : S_DATA_HI;
      S_DATA_HI: if (w_accept) w_state_nxt = S_DATA_LO;
      S_DATA_LO: if (w_accept) w_state_nxt = S_WRITE;
      S_WRITE:   w_state_nxt = w_last ? S_AFTER_LAST : S_DATA_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:    if (w_accept) w_state_nxt = w_csum_match ? S_DONE : S_ERR;
`endif
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and outputs registered from the next state so every
  // output is valid in the same cycle as the state it describes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cpu_start <= 1'b0;
      r_len       <= '0;
      r_hi        <= '0;
      r_addr      <= '0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rx_ready  <= is_rx_state(w_state_nxt);
      r_busy      <= is_busy_state(w_state_nxt);
      r_wr_en     <= (w_state_nxt == S_WRITE);
      r_done      <= (w_state_nxt == S_DONE);
      r_error     <= (w_state_nxt == S_ERR);
      r_cpu_start <= (w_state_nxt == S_DONE) && (r_state != S_DONE);

      if (w_start) begin
        r_len   <= '0;
        r_addr  <= '0;
        r_count <= '0;
      end

      if (w_accept) begin
        case (r_state)
          S_LEN_HI:  r_len[LEN_W-1 -: BYTE_W] <= bus.rx_data;
          S_LEN_LO:  r_len[BYTE_W-1:0]        <= bus.rx_data;
          S_DATA_HI: r_hi                     <= bus.rx_data;
          S_DATA_LO: r_wr_data                <= {r_hi, bus.rx_data};
          default:   ;
        endcase
      end

      // Address wraps naturally; after a full-depth load it returns to 0
      if (r_state == S_WRITE) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.rx_ready  = r_rx_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
  assign bus.cpu_start = r_cpu_start;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table plus scoreboard of
// expected memory writes; covers the checksum build when the macro is set.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [7:0]  len_hi;
    logic [7:0]  len_lo;
    int          nwords;
    logic [15:0] w0;
    logic [15:0] w1;
    int          gap;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  localparam int NVEC = 5;

  vec_t              vecs [NVEC];
  wr_t               exp_q [$];
  wr_t               mon_e;
  int                n_checks;
  int                n_fail;
  int                n_start_pulses;
  logic              prev_start;
  logic [ADDR_W-1:0] last_wr_addr;
  logic [7:0]        csum_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_en) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write",
                   bus.wr_addr, bus.wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          n_checks--;
          check("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
          check("wr_data", 32'(bus.wr_data), 32'(mon_e.data));
        end
        last_wr_addr = bus.wr_addr;
      end
      if (bus.cpu_start) begin
        n_start_pulses++;
        if (prev_start) begin
          n_checks++;
          n_fail++;
          $display("FAIL cpu_start_width: got 2+ cycles expected 1");
        end
      end
      prev_start = bus.cpu_start;
    end else begin
      prev_start = 1'b0;
    end
  end

  // All tasks are entered and left on a falling clock edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    if (gap > 2) check("rx_ready_stall", 32'(bus.rx_ready), 32'd1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("rx_ready_timeout", 32'(n), 32'd0);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    csum_acc ^= b;
  endtask

  task automatic start_load();
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
    csum_acc = 8'h00;
    n_start_pulses = 0;
  endtask

  task automatic send_len(input int n, input int gap);
    logic [15:0] l;
    l = 16'(n);
    send_byte(l[15:8], gap);
    send_byte(l[7:0], gap);
  endtask

  task automatic send_word(input int addr, input logic [15:0] w, input int gap);
    wr_t e;
    e.addr = ADDR_W'(addr);
    e.data = w;
    exp_q.push_back(e);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic send_csum(input int gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = csum_acc;
    send_byte(c, gap);
`else
    if (gap < 0) $display("negative gap %0d", gap);
`endif
  endtask

  task automatic finish_vec(input bit exp_done, input bit exp_err);
    int n;
    n = 0;
    while (!(bus.done || bus.error) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("end_timeout", 32'(n), 32'd0);
    repeat (3) @(negedge clk);
    check("done",      32'(bus.done),      32'(exp_done));
    check("error",     32'(bus.error),     32'(exp_err));
    check("busy_end",  32'(bus.busy),      32'd0);
    check("rdy_end",   32'(bus.rx_ready),  32'd0);
    check("start_cnt", 32'(n_start_pulses), exp_done ? 32'd1 : 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({bus.rx_ready, bus.wr_en, bus.wr_addr, bus.wr_data,
                bus.busy, bus.done, bus.error, bus.cpu_start});
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_start_pulses = 0;
    prev_start = 1'b0;
    last_wr_addr = '0;
    csum_acc = 8'h00;
    bus.load_req = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n = 1'b0;

    vecs[0] = '{8'h00, 8'h02, 2, 16'h1234, 16'hABCD, 0, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 8'h02, 2, 16'h1234, 16'hABCD, 5, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
    vecs[3] = '{8'h02, 8'h01, 0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 8'h01, 1, 16'hBEEF, 16'h0000, 1, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs", all_outputs(), 32'd0);

    // Reset mid-stream after three bytes
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", all_outputs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_rdy", 32'(bus.rx_ready), 32'd0);
    check("post_reset_busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      start_load();
      send_byte(vecs[i].len_hi, vecs[i].gap);
      send_byte(vecs[i].len_lo, vecs[i].gap);
      if (!vecs[i].exp_err) begin
        if (vecs[i].nwords > 0) send_word(0, vecs[i].w0, vecs[i].gap);
        if (vecs[i].nwords > 1) send_word(1, vecs[i].w1, vecs[i].gap);
        send_csum(vecs[i].gap);
      end
      finish_vec(vecs[i].exp_done, vecs[i].exp_err);
    end

    // load_req while waiting in DATA_LO must be ignored
    start_load();
    send_len(2, 0);
    begin
      wr_t e;
      e.addr = '0;
      e.data = 16'h1234;
      exp_q.push_back(e);
    end
    send_byte(8'h12, 0);
    bus.load_req = 1'b1;
    @(negedge clk);
    bus.load_req = 1'b0;
    send_byte(8'h34, 0);
    send_word(1, 16'hABCD, 0);
    send_csum(0);
    finish_vec(1'b1, 1'b0);

    // Full-depth image: word i = i, address wraps back to 0
    start_load();
    send_len(DEPTH, 0);
    for (int i = 0; i < int'(DEPTH); i++) send_word(i, 16'(i), 0);
    send_csum(0);
    finish_vec(1'b1, 1'b0);
    check("last_wr_addr", 32'(last_wr_addr), 32'd511);
    check("wr_addr_wrap", 32'(bus.wr_addr), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    begin
      wr_t e;
      e.addr = '0;
      e.data = 16'h1234;
      start_load();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      exp_q.push_back(e);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h27, 0);
      finish_vec(1'b1, 1'b0);

      start_load();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      exp_q.push_back(e);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      send_byte(8'h28, 0);
      finish_vec(1'b0, 1'b1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
